// File: rtl/lsh_sequencer.sv
// Stream controller for the LSH datapath: builds overlapping symbol windows and sequences hasher, hash table and stats.
// Optional hash watchdog is compiled in with the LSH_SEQ_TIMEOUT_EN macro.
module lsh_sequencer #(
  parameter int WINDOW_SIZE              = 128,
  parameter int KMER_SIZE                = 16,
  parameter int MAX_WINDOWS_IN_REFERENCE = 512,
  parameter int PULSE_CYCLES             = 2,
  parameter int HASH_TIMEOUT             = 4096
) (
  input  logic                     clk,
  input  logic                     reset_lsh_sequencer,
  input  logic                     start,
  input  logic                     is_reference_mode,
  input  logic                     sym_valid,
  input  logic [1:0]               sym_data,
  input  logic                     sym_last,
  output logic                     sym_ready,
  output logic [2*WINDOW_SIZE-1:0] window,
  output logic                     ready_for_hashing,
  input  logic                     hashing_is_done,
  output logic                     reset_window_hasher,
  output logic                     reset_stats,
  output logic                     is_insert,
  output logic                     is_query,
  output logic [31:0]              window_id,
  output logic                     calculate_matched_window,
  input  logic signed [31:0]       matched_window_id,
  output logic signed [31:0]       result_id,
  output logic                     done,
  output logic                     overflow,
  output logic                     hash_timeout
);
  localparam int STEP = WINDOW_SIZE - KMER_SIZE + 1;
  localparam int FW   = $clog2(WINDOW_SIZE + 1);
  localparam int PW   = $clog2(PULSE_CYCLES + 1);
  localparam logic [FW-1:0] NEED_FIRST = FW'(WINDOW_SIZE);
  localparam logic [FW-1:0] NEED_STEP  = FW'(STEP);

  typedef enum logic [2:0] {IDLE, START_RST, FILL, HASH, COMMIT, HRST, FINISH, DONE} state_t;
  state_t state, state_nx;

  logic          ref_mode, first_win, last_win;
  logic [FW-1:0] fcnt, fcnt_inc, need;
  logic [PW-1:0] pcnt;
  logic          pulse_end, accept, win_full, skip, hash_to;

  assign pulse_end = (pcnt == PW'(PULSE_CYCLES - 1));
  assign accept    = (state == FILL) && sym_valid;
  assign need      = first_win ? NEED_FIRST : NEED_STEP;
  assign fcnt_inc  = fcnt + 1'b1;
  assign win_full  = accept && (fcnt_inc == need);
  // Once the reference table is full, completed windows are dropped while the stream drains.
  assign skip      = ref_mode && (overflow || window_id == 32'(MAX_WINDOWS_IN_REFERENCE));

`ifdef LSH_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(HASH_TIMEOUT + 1);
  logic [TW-1:0] tcnt;
  logic          to_flag;

  assign hash_to      = (state == HASH) && !hashing_is_done && (tcnt == TW'(HASH_TIMEOUT - 1));
  assign hash_timeout = to_flag;

  always_ff @(posedge clk or posedge reset_lsh_sequencer) begin
    if (reset_lsh_sequencer) begin
      tcnt    <= '0;
      to_flag <= 1'b0;
    end else begin
      tcnt <= (state == HASH) ? tcnt + 1'b1 : '0;
      if (state == IDLE && start) to_flag <= 1'b0;
      else if (hash_to)           to_flag <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = |HASH_TIMEOUT;
  assign hash_to        = 1'b0;
  assign hash_timeout   = 1'b0;
`endif

  always_comb begin
    state_nx                 = state;
    sym_ready                = 1'b0;
    ready_for_hashing        = 1'b0;
    reset_window_hasher      = 1'b0;
    reset_stats              = 1'b0;
    is_insert                = 1'b0;
    is_query                 = 1'b0;
    calculate_matched_window = 1'b0;
    done                     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = START_RST;
      START_RST: begin
        reset_window_hasher = 1'b1;
        reset_stats         = 1'b1;
        if (pulse_end) state_nx = FILL;
      end
      FILL: begin
        sym_ready = 1'b1;
        if (accept) begin
          if (win_full && !skip) state_nx = HASH;
          else if (sym_last)     state_nx = FINISH;
        end
      end
      HASH: begin
        ready_for_hashing = 1'b1;
        if (hashing_is_done) state_nx = COMMIT;
        else if (hash_to)    state_nx = FINISH;
      end
      COMMIT: begin
        is_insert = ref_mode;
        is_query  = !ref_mode;
        if (pulse_end) state_nx = last_win ? FINISH : HRST;
      end
      HRST: begin
        reset_window_hasher = 1'b1;
        if (pulse_end) state_nx = FILL;
      end
      FINISH: begin
        calculate_matched_window = !ref_mode && !hash_timeout;
        if (ref_mode || hash_timeout || pulse_end) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_lsh_sequencer) begin
    if (reset_lsh_sequencer) begin
      state     <= IDLE;
      window    <= '0;
      window_id <= '0;
      ref_mode  <= 1'b0;
      first_win <= 1'b1;
      last_win  <= 1'b0;
      fcnt      <= '0;
      pcnt      <= '0;
      result_id <= -32'sd1;
      overflow  <= 1'b0;
    end else begin
      state <= state_nx;
      // pcnt times every pulse state; it restarts on each state change.
      pcnt  <= (state_nx != state) ? '0 : pcnt + 1'b1;
      case (state)
        IDLE: if (start) begin
          ref_mode  <= is_reference_mode;
          window_id <= '0;
          overflow  <= 1'b0;
          result_id <= -32'sd1;
          first_win <= 1'b1;
          last_win  <= 1'b0;
          fcnt      <= '0;
        end
        FILL: if (accept) begin
          window <= {sym_data, window[2*WINDOW_SIZE-1:2]};
          fcnt   <= win_full ? '0 : fcnt_inc;
          if (win_full) begin
            first_win <= 1'b0;
            last_win  <= sym_last;
            if (skip) overflow <= 1'b1;
          end
        end
        COMMIT: if (pulse_end) window_id <= window_id + 32'd1;
        FINISH: if (!ref_mode && !hash_timeout && pulse_end) result_id <= matched_window_id;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lsh_sequencer.sv
// Directed bench for lsh_sequencer (WINDOW_SIZE=8, KMER_SIZE=4, STEP=5, reference limit of 2 windows).
module tb_lsh_sequencer;
  logic               clk = 1'b0;
  logic               reset_lsh_sequencer = 1'b1;
  logic               start = 1'b0, is_reference_mode = 1'b0;
  logic               sym_valid = 1'b0, sym_last = 1'b0;
  logic [1:0]         sym_data = 2'b00;
  logic               sym_ready;
  logic [15:0]        window;
  logic               ready_for_hashing, hashing_is_done = 1'b0;
  logic               reset_window_hasher, reset_stats, is_insert, is_query;
  logic [31:0]        window_id;
  logic               calculate_matched_window;
  logic signed [31:0] matched_window_id = -32'sd1;
  logic signed [31:0] result_id;
  logic               done, overflow, hash_timeout;

  lsh_sequencer #(.WINDOW_SIZE(8), .KMER_SIZE(4), .MAX_WINDOWS_IN_REFERENCE(2),
                  .PULSE_CYCLES(2), .HASH_TIMEOUT(10)) dut (
    .clk(clk), .reset_lsh_sequencer(reset_lsh_sequencer), .start(start),
    .is_reference_mode(is_reference_mode), .sym_valid(sym_valid), .sym_data(sym_data),
    .sym_last(sym_last), .sym_ready(sym_ready), .window(window),
    .ready_for_hashing(ready_for_hashing), .hashing_is_done(hashing_is_done),
    .reset_window_hasher(reset_window_hasher), .reset_stats(reset_stats),
    .is_insert(is_insert), .is_query(is_query), .window_id(window_id),
    .calculate_matched_window(calculate_matched_window),
    .matched_window_id(matched_window_id), .result_id(result_id), .done(done),
    .overflow(overflow), .hash_timeout(hash_timeout));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  bit hash_en = 1'b1, clr = 1'b0;
  int hd_cnt = 0;
  int n_ins, n_qry, n_rfh, n_cmw, n_done, n_rs, n_rwh;
  logic [31:0] ids[$];
  logic [15:0] wins[$];
  bit prev_rfh;

  // Hasher model: raises hashing_is_done on the third cycle of ready_for_hashing.
  always @(negedge clk) begin
    if (ready_for_hashing && hash_en) begin
      hd_cnt++;
      hashing_is_done = (hd_cnt == 3);
    end else begin
      hd_cnt = 0;
      hashing_is_done = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (clr) begin
      n_ins = 0; n_qry = 0; n_rfh = 0; n_cmw = 0; n_done = 0; n_rs = 0; n_rwh = 0;
      ids.delete(); wins.delete(); prev_rfh = 1'b0;
    end else begin
      if (is_insert) begin n_ins++; ids.push_back(window_id); end
      if (is_query)  begin n_qry++; ids.push_back(window_id); end
      if (ready_for_hashing) begin
        n_rfh++;
        if (!prev_rfh) wins.push_back(window);
      end
      prev_rfh = ready_for_hashing;
      n_cmw  += int'(calculate_matched_window);
      n_done += int'(done);
      n_rs   += int'(reset_stats);
      n_rwh  += int'(reset_window_hasher);
    end
  end

  task automatic clear_mon();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic pulse_start(input logic mode);
    @(negedge clk); start = 1'b1; is_reference_mode = mode;
    @(negedge clk); start = 1'b0; is_reference_mode = 1'b0;
  endtask

  task automatic push(input logic [1:0] d, input logic l, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (sym_ready) begin
        sym_valid = 1'b1; sym_data = d; sym_last = l;
        @(posedge clk); #1;
        sym_valid = 1'b0; sym_last = 1'b0;
        ok = 1'b1;
      end
    end
  endtask

  // Symbols follow (i+off)%4; sym_last rides on symbol n-1.
  task automatic send(input logic mode, input int n, input int off, output int acc);
    bit ok;
    acc = 0;
    pulse_start(mode);
    for (int i = 0; i < n; i++) begin
      push(2'((i + off) % 4), (i == n - 1), ok);
      acc += int'(ok);
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk); #1;
      if (n_done > 0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset_lsh_sequencer = 1'b1;
    repeat (3) @(negedge clk);
    total++; if ({sym_ready, ready_for_hashing, reset_window_hasher, reset_stats, is_insert, is_query,
                  calculate_matched_window, done, overflow, hash_timeout} !== 10'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=0", {sym_ready, ready_for_hashing, reset_window_hasher,
        reset_stats, is_insert, is_query, calculate_matched_window, done, overflow, hash_timeout});
    end
    total++; if (window !== 16'h0 || window_id !== 32'd0) begin
      bad++; $display("FAIL reset_window got=%h/%0d exp=0/0", window, window_id);
    end
    total++; if (result_id !== -32'sd1) begin
      bad++; $display("FAIL reset_result got=%0d exp=-1", result_id);
    end
    reset_lsh_sequencer = 1'b0;
  endtask

  task automatic test_ref_two_windows();
    int acc; bit ok;
    clear_mon();
    send(1'b1, 13, 0, acc);
    wait_done(ok);
    total++; if (!ok) begin bad++; $display("FAIL t1_done got=timeout exp=done"); end
    total++; if (n_ins !== 4 || n_qry !== 0) begin
      bad++; $display("FAIL t1_pulses got=ins%0d/qry%0d exp=4/0", n_ins, n_qry);
    end
    total++; if (ids.size() != 4 || ids[0] !== 0 || ids[1] !== 0 || ids[2] !== 1 || ids[3] !== 1) begin
      bad++; $display("FAIL t1_ids got=%p exp=0,0,1,1", ids);
    end
    total++; if (wins.size() != 2 || wins[0] !== 16'hE4E4 || wins[1] !== 16'h3939) begin
      bad++; $display("FAIL t1_windows got=%p exp=e4e4,3939", wins);
    end
    total++; if (n_rs !== 2 || n_rwh !== 4) begin
      bad++; $display("FAIL t1_resets got=rs%0d/rwh%0d exp=2/4", n_rs, n_rwh);
    end
    total++; if (result_id !== -32'sd1 || window_id !== 32'd2 || n_done !== 1 || n_cmw !== 0) begin
      bad++; $display("FAIL t1_end got=res%0d/id%0d/done%0d/cmw%0d exp=-1/2/1/0", result_id, window_id, n_done, n_cmw);
    end
    total++; if (hash_timeout !== 1'b0 || overflow !== 1'b0) begin
      bad++; $display("FAIL t1_flags got=to%b/ov%b exp=0/0", hash_timeout, overflow);
    end
  endtask

  task automatic test_read_match();
    int acc; bit ok;
    clear_mon();
    matched_window_id = 32'sd3;
    send(1'b0, 8, 2, acc);
    wait_done(ok);
    total++; if (!ok) begin bad++; $display("FAIL t2_done got=timeout exp=done"); end
    total++; if (n_qry !== 2 || n_ins !== 0 || ids.size() != 2 || ids[0] !== 0 || ids[1] !== 0) begin
      bad++; $display("FAIL t2_query got=qry%0d/ins%0d/%p exp=2/0/0,0", n_qry, n_ins, ids);
    end
    total++; if (wins.size() != 1 || wins[0] !== 16'h4E4E) begin
      bad++; $display("FAIL t2_window got=%p exp=4e4e", wins);
    end
    total++; if (n_cmw !== 2 || result_id !== 32'sd3 || n_done !== 1) begin
      bad++; $display("FAIL t2_result got=cmw%0d/res%0d/done%0d exp=2/3/1", n_cmw, result_id, n_done);
    end
  endtask

  task automatic test_read_partial();
    int acc; bit ok;
    clear_mon();
    matched_window_id = -32'sd1;
    send(1'b0, 5, 1, acc);
    wait_done(ok);
    total++; if (!ok || acc !== 5) begin bad++; $display("FAIL t3_done got=ok%0d/acc%0d exp=1/5", ok, acc); end
    total++; if (n_rfh !== 0 || n_qry !== 0 || n_cmw !== 2 || result_id !== -32'sd1) begin
      bad++; $display("FAIL t3_partial got=rfh%0d/qry%0d/cmw%0d/res%0d exp=0/0/2/-1", n_rfh, n_qry, n_cmw, result_id);
    end
  endtask

  task automatic test_overflow();
    int acc; bit ok;
    clear_mon();
    send(1'b1, 18, 3, acc);
    wait_done(ok);
    total++; if (!ok || acc !== 18) begin bad++; $display("FAIL t4_accept got=ok%0d/acc%0d exp=1/18", ok, acc); end
    total++; if (n_ins !== 4 || n_rfh !== 6 || wins.size() != 2) begin
      bad++; $display("FAIL t4_inserts got=ins%0d/rfh%0d/win%0d exp=4/6/2", n_ins, n_rfh, wins.size());
    end
    total++; if (overflow !== 1'b1 || window_id !== 32'd2 || n_done !== 1 || result_id !== -32'sd1) begin
      bad++; $display("FAIL t4_overflow got=ov%b/id%0d/done%0d/res%0d exp=1/2/1/-1", overflow, window_id, n_done, result_id);
    end
  endtask

  task automatic test_reset_mid_hash();
    int acc; bit ok;
    clear_mon();
    hash_en = 1'b0;
    send(1'b0, 8, 1, acc);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk); if (ready_for_hashing) ok = 1'b1;
    end
    total++; if (!ok) begin bad++; $display("FAIL t5_hash got=no_hash exp=hash"); end
    #1 reset_lsh_sequencer = 1'b1;
    #1;
    total++; if ({ready_for_hashing, sym_ready, is_query, overflow, done} !== 5'b0 || window !== 16'h0
                 || window_id !== 32'd0 || result_id !== -32'sd1) begin
      bad++; $display("FAIL t5_async got=rfh%b/win%h/id%0d/res%0d exp=0/0/0/-1", ready_for_hashing, window, window_id, result_id);
    end
    @(negedge clk); reset_lsh_sequencer = 1'b0; hash_en = 1'b1;
    clear_mon();
    matched_window_id = 32'sd3;
    pulse_start(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) pulse_start(1'b1);
      push(2'((i + 2) % 4), (i == 7), ok);
    end
    wait_done(ok);
    total++; if (!ok || n_qry !== 2 || n_ins !== 0 || n_rs !== 2) begin
      bad++; $display("FAIL t5_rerun got=ok%0d/qry%0d/ins%0d/rs%0d exp=1/2/0/2", ok, n_qry, n_ins, n_rs);
    end
    total++; if (result_id !== 32'sd3 || n_cmw !== 2) begin
      bad++; $display("FAIL t5_result got=res%0d/cmw%0d exp=3/2", result_id, n_cmw);
    end
  endtask

`ifdef LSH_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int acc; bit ok;
    clear_mon();
    hash_en = 1'b0;
    matched_window_id = 32'sd5;
    send(1'b0, 8, 0, acc);
    wait_done(ok);
    total++; if (!ok || n_rfh !== 10 || hash_timeout !== 1'b1) begin
      bad++; $display("FAIL t6_timeout got=ok%0d/rfh%0d/to%b exp=1/10/1", ok, n_rfh, hash_timeout);
    end
    total++; if (n_qry !== 0 || n_ins !== 0 || n_cmw !== 0 || result_id !== -32'sd1 || n_done !== 1) begin
      bad++; $display("FAIL t6_finish got=qry%0d/cmw%0d/res%0d/done%0d exp=0/0/-1/1", n_qry, n_cmw, result_id, n_done);
    end
    hash_en = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_ref_two_windows();
    test_read_match();
    test_read_partial();
    test_overflow();
    test_reset_mid_hash();
`ifdef LSH_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
